image_stream_loader: RTL and testbench
======================================

// Module: image_stream_loader
// PURPOSE
//  Writer side of the input-image memory. Accepts a pixel stream (valid/ready/last) and writes
//  pixels to consecutive addresses of the input memory. After the final write it fires a one-cycle
//  new_image_pulse to the histogram equalizer top. Replaces preloading the input memory by file,
//  then blocks new images until the core reports completion.
// PARAMETERS
//  PIXEL_W  8   pixel width, bits
//  ADDR_W   16  input-memory address width
//  DEPTH_W  17  width of depth/count values (ADDR_W+1, so a full 1<<16 image is representable)
// PORTS
//  clock            in   1        single clock, all logic on posedge
//  reset            in   1        synchronous, active-low (0 at posedge = reset)
//  input_mem_depth  in   DEPTH_W  max pixels per image, sampled when a load starts
//  s_valid          in   1        stream beat valid
//  s_data           in   PIXEL_W  stream pixel
//  s_last           in   1        final beat of image
//  s_ready          out  1        loader accepts beat this cycle
//  mem_we           out  1        input-memory write enable
//  mem_addr         out  ADDR_W   write address
//  mem_wdata        out  PIXEL_W  write data
//  new_image_pulse  out  1        one-cycle start strobe to core
//  core_done        in   1        core finished current image (pulse)
//  pixel_count      out  DEPTH_W  pixels written for current/last image
//  overflow         out  1        sticky: stream longer than depth, excess dropped
// BEHAVIOUR
//  - Reset: state IDLE; s_ready, mem_we, new_image_pulse, overflow = 0; mem_addr, mem_wdata,
//    pixel_count = 0. All outputs are registered.
//  - Beat accepted = s_valid & s_ready at a posedge.
//  - States: IDLE, LOAD, DRAIN, PULSE, WAIT_CORE.
//  - IDLE: s_ready=1 iff input_mem_depth!=0.
//    First accepted beat: latch depth, clear overflow, write addr 0, pixel_count=1.
//    Next state: LOAD, or PULSE if s_last or depth==1.
//  - LOAD: each accepted beat writes addr=pixel_count, then pixel_count++.
//    * s_last on the beat -> PULSE.
//    * Else pixel_count reaching depth on the beat -> DRAIN, overflow=1.
//    * If both happen on the same beat -> PULSE, overflow stays 0.
//  - Write timing: accepted beat at edge N -> mem_we/mem_addr/mem_wdata valid for cycle N..N+1.
//    mem_we=0 on every cycle with no accepted beat. Addresses are contiguous regardless of
//    valid gaps.
//  - s_ready drops (registered) at the edge that accepts the terminating beat, so there is no
//    extra acceptance.
//  - DRAIN: s_ready=1, beats discarded with no mem_we; s_last -> PULSE.
//  - PULSE: s_ready=0; new_image_pulse=1 for exactly one cycle, asserted the cycle after the
//    last mem_we cycle; -> WAIT_CORE.
//  - WAIT_CORE: s_ready=0; core_done -> IDLE (s_ready=1 next cycle). core_done ignored in
//    every other state.
//  - Depth 0: never leaves IDLE, s_ready stays 0.
//  - Reset mid-operation: load aborts, no pulse, pixel_count=0. Memory contents are not cleared.
//  - pixel_count holds its final value until the next load starts.
// STRUCTURE
//  - Shared header hist_defs.vh: PIXEL_W, ADDR_W, DEPTH_W, state encodings (3-bit localparams).
//  - Single module, no sub-modules: one FSM plus one DEPTH_W counter.
// TESTING
//  1. Reset: reset=0 for 3 cycles with s_valid=1 -> s_ready=0, mem_we=0, new_image_pulse=0,
//     pixel_count=0.
//  2. Normal: depth=4, beats 0x10,0x20,0x30,0x40 back-to-back, s_last on 4th
//     -> mem_we 4 consecutive cycles, addr 0..3 with that data; pulse 1 cycle after 4th write;
//     pixel_count=4; overflow=0.
//  3. Gaps: depth=4, s_valid toggled 1,0,1,0,... -> mem_we only on accepted cycles; addr 0,1,2,3
//     contiguous; single pulse.
//  4. Overflow: depth=2, beats 0xAA,0xBB,0xCC, s_last on 3rd -> writes addr0=AA, addr1=BB only;
//     overflow=1; one pulse after s_last.
//  5. Exact fit: depth=2, s_last on 2nd -> overflow=0, pulse.
//     Then in WAIT_CORE s_ready=0 for 10 cycles; core_done -> s_ready=1 next cycle.
//  6. Reset mid-load after 2 beats of a depth=8 image -> no new_image_pulse, pixel_count=0;
//     next image loads from addr 0.

Source files
------------

// File: rtl/image_stream_loader_pkg.sv
// Shared widths, state encoding and handy typedefs for the image stream loader.
package image_stream_loader_pkg;

    localparam int unsigned PIXEL_W = 8;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DEPTH_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLoad     = 3'd1,
        StDrain    = 3'd2,
        StPulse    = 3'd3,
        StWaitCore = 3'd4
    } state_e;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DEPTH_W-1:0] count_t;

endpackage

// File: rtl/image_stream_loader_if.sv
// Pixel stream handshake (valid/ready/last) between a pixel source and the loader.
interface image_stream_loader_if;
    import image_stream_loader_pkg::*;

    logic   s_valid;
    pixel_t s_data;
    logic   s_last;
    logic   s_ready;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/image_stream_loader.sv
// Writes a pixel stream into consecutive input-memory addresses, then strobes the core
// and holds off further images until the core reports completion.
module image_stream_loader
    import image_stream_loader_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  count_t                      input_mem_depth,
    image_stream_loader_if.slave        strm,
    output logic                        mem_we,
    output addr_t                       mem_addr,
    output pixel_t                      mem_wdata,
    output logic                        new_image_pulse,
    input  logic                        core_done,
    output count_t                      pixel_count,
    output logic                        overflow
);

    state_e state_q, state_d;
    logic   s_ready_q, s_ready_d;
    logic   mem_we_q, mem_we_d;
    addr_t  mem_addr_q, mem_addr_d;
    pixel_t mem_wdata_q, mem_wdata_d;
    logic   pulse_q, pulse_d;
    count_t pixel_count_q, pixel_count_d;
    count_t depth_q, depth_d;
    logic   overflow_q, overflow_d;

    logic   accept;
    count_t count_inc;

    assign accept    = strm.s_valid & s_ready_q;
    assign count_inc = pixel_count_q + count_t'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            s_ready_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            pulse_q       <= 1'b0;
            pixel_count_q <= '0;
            depth_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= s_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            pulse_q       <= pulse_d;
            pixel_count_q <= pixel_count_d;
            depth_q       <= depth_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (strm.s_last || input_mem_depth == count_t'(1)) ? StPulse : StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (strm.s_last) begin
                        state_d = StPulse;
                    end else if (count_inc == depth_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (accept && strm.s_last) begin
                    state_d = StPulse;
                end
            end
            StPulse:    state_d = StWaitCore;
            StWaitCore: begin
                if (core_done) begin
                    state_d = StIdle;
                end
            end
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready_d     = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        pulse_d       = 1'b0;
        pixel_count_d = pixel_count_q;
        depth_d       = depth_q;
        overflow_d    = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    depth_d       = input_mem_depth;
                    overflow_d    = 1'b0;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = '0;
                    mem_wdata_d   = strm.s_data;
                    pixel_count_d = count_t'(1);
                end
            end
            StLoad: begin
                if (accept) begin
                    mem_we_d      = 1'b1;
                    mem_addr_d    = addr_t'(pixel_count_q);
                    mem_wdata_d   = strm.s_data;
                    pixel_count_d = count_inc;
                    // A last beat that exactly fills the image is not an overflow
                    if (!strm.s_last && count_inc == depth_q) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            StPulse: pulse_d = 1'b1;
            default: ;
        endcase

        // Ready tracks the state being entered, so the terminating beat is the last one taken
        unique case (state_d)
            StIdle:          s_ready_d = (input_mem_depth != '0);
            StLoad, StDrain: s_ready_d = 1'b1;
            default:         s_ready_d = 1'b0;
        endcase
    end

    assign strm.s_ready    = s_ready_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign new_image_pulse = pulse_q;
    assign pixel_count     = pixel_count_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Self-checking bench: table of image scenarios, hand-written reset/depth-0 sequences and
// random images checked against a simple "first min(n,depth) beats land at 0.." model.
module tb_image_stream_loader;
    import image_stream_loader_pkg::*;

    logic   clock = 1'b0;
    logic   reset = 1'b0;
    count_t input_mem_depth = '0;
    logic   mem_we;
    addr_t  mem_addr;
    pixel_t mem_wdata;
    logic   new_image_pulse;
    logic   core_done = 1'b0;
    count_t pixel_count;
    logic   overflow;

    image_stream_loader_if s_if ();

    image_stream_loader dut (
        .clock           (clock),
        .reset           (reset),
        .input_mem_depth (input_mem_depth),
        .strm            (s_if),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .new_image_pulse (new_image_pulse),
        .core_done       (core_done),
        .pixel_count     (pixel_count),
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int depth;
        int n;
        int base;
        int stp;
        int gap;
        int exp_cnt;
        bit exp_ov;
        int core_wait;
    } vec_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    addr_t  wa_q[$];
    pixel_t wd_q[$];
    int     pulses = 0;
    int     acc_idx = 0;
    int     cur_depth = 0;
    logic   prev_we = 1'b0;
    logic   pulse_prev_we = 1'b0;
    vec_t   tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: a write is expected exactly when a beat is taken and the image still has room
    task automatic step();
        logic acc;
        logic in_rst;
        logic exp_we;
        acc    = s_if.s_valid && s_if.s_ready;
        in_rst = !reset;
        @(posedge clock);
        #1;
        if (!in_rst) begin
            exp_we = 1'b0;
            if (acc) begin
                exp_we = (acc_idx < cur_depth);
                acc_idx++;
            end
            check("mem_we", mem_we, exp_we);
        end
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (new_image_pulse) begin
            pulses++;
            pulse_prev_we = prev_we;
        end
        prev_we = mem_we;
    endtask

    task automatic send_beat(input pixel_t d, input logic last, output bit ok);
        int waitc = 0;
        bit taken = 0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = last;
        ok = 1'b1;
        while (!taken) begin
            taken = s_if.s_ready;
            step();
            waitc++;
            if (!taken && waitc > 40) begin
                check("beat_accept_timeout", 0, 1);
                ok = 1'b0;
                taken = 1'b1;
            end
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        core_done    = 1'b0;
    endtask

    task automatic release_core(input int nwait, input string tag);
        for (int i = 0; i < nwait; i++) begin
            step();
            check({tag, "_ready_in_wait"}, s_if.s_ready, 0);
        end
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check({tag, "_ready_after_done"}, s_if.s_ready, 1);
    endtask

    task automatic run_image(input vec_t v, input string tag);
        bit ok;
        int waitc;
        wa_q.delete();
        wd_q.delete();
        pulses    = 0;
        acc_idx   = 0;
        cur_depth = v.depth;
        input_mem_depth = count_t'(v.depth);
        for (int i = 0; i < v.n; i++) begin
            if (v.gap == 1 && i > 0) begin
                step();
            end else if (v.gap == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    // core_done outside WAIT_CORE must be ignored
                    core_done = 1'($urandom_range(0, 1));
                    step();
                end
                core_done = 1'b0;
            end
            send_beat(pixel_t'(v.base + i * v.stp), (i == v.n - 1), ok);
            if (!ok) break;
        end
        waitc = 0;
        while (pulses == 0 && waitc < 12) begin
            step();
            waitc++;
        end
        check({tag, "_pulse_seen"}, (pulses != 0), 1);
        if (!v.exp_ov) check({tag, "_pulse_after_write"}, pulse_prev_we, 1);
        step();
        step();
        check({tag, "_pulse_count"}, pulses, 1);
        check({tag, "_write_count"}, wa_q.size(), v.exp_cnt);
        for (int k = 0; k < wa_q.size() && k < v.exp_cnt; k++) begin
            check({tag, "_addr"}, wa_q[k], k);
            check({tag, "_data"}, wd_q[k], pixel_t'(v.base + k * v.stp));
        end
        check({tag, "_pixel_count"}, pixel_count, v.exp_cnt);
        check({tag, "_overflow"}, overflow, v.exp_ov);
    endtask

    initial begin
        bit   ok;
        vec_t rv;

        tbl[0] = '{depth: 4, n: 4, base: 'h10, stp: 'h10, gap: 0, exp_cnt: 4, exp_ov: 0, core_wait: 3};
        tbl[1] = '{depth: 4, n: 4, base: 'h21, stp: 'h05, gap: 1, exp_cnt: 4, exp_ov: 0, core_wait: 3};
        tbl[2] = '{depth: 2, n: 3, base: 'hAA, stp: 'h11, gap: 0, exp_cnt: 2, exp_ov: 1, core_wait: 3};
        tbl[3] = '{depth: 2, n: 2, base: 'h5A, stp: 'h01, gap: 0, exp_cnt: 2, exp_ov: 0, core_wait: 10};
        tbl[4] = '{depth: 1, n: 1, base: 'h77, stp: 'h00, gap: 0, exp_cnt: 1, exp_ov: 0, core_wait: 3};
        tbl[5] = '{depth: 3, n: 7, base: 'h01, stp: 'h03, gap: 1, exp_cnt: 3, exp_ov: 1, core_wait: 3};

        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'h99;
        s_if.s_last  = 1'b0;
        input_mem_depth = count_t'(4);
        reset = 1'b0;
        repeat (3) step();
        check("reset_s_ready", s_if.s_ready, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_pulse", new_image_pulse, 0);
        check("reset_pixel_count", pixel_count, 0);
        check("reset_overflow", overflow, 0);
        check("reset_mem_addr", mem_addr, 0);
        s_if.s_valid = 1'b0;
        reset = 1'b1;
        step();

        for (int t = 0; t < 6; t++) begin
            run_image(tbl[t], $sformatf("tbl%0d", t));
            release_core(tbl[t].core_wait, $sformatf("tbl%0d", t));
        end

        // Depth 0: loader must never take a beat and pixel_count keeps its last value
        input_mem_depth = '0;
        step();
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'h3C;
        repeat (5) step();
        check("depth0_s_ready", s_if.s_ready, 0);
        check("depth0_pixel_count_held", pixel_count, tbl[5].exp_cnt);
        s_if.s_valid = 1'b0;

        // Reset in the middle of a depth-8 load
        wa_q.delete();
        wd_q.delete();
        pulses    = 0;
        acc_idx   = 0;
        cur_depth = 8;
        input_mem_depth = count_t'(8);
        send_beat(8'hE1, 1'b0, ok);
        send_beat(8'hE2, 1'b0, ok);
        check("midrst_writes_before", wa_q.size(), 2);
        s_if.s_valid = 1'b1;
        reset = 1'b0;
        step();
        s_if.s_valid = 1'b0;
        check("midrst_pixel_count", pixel_count, 0);
        check("midrst_s_ready", s_if.s_ready, 0);
        reset = 1'b1;
        repeat (6) step();
        check("midrst_no_pulse", pulses, 0);
        run_image(tbl[0], "after_rst");
        release_core(2, "after_rst");

        for (int r = 0; r < 20; r++) begin
            rv.depth     = $urandom_range(2, 10);
            rv.n         = $urandom_range(1, 14);
            rv.base      = $urandom_range(0, 255);
            rv.stp       = $urandom_range(0, 255);
            rv.gap       = 2;
            rv.exp_cnt   = (rv.n < rv.depth) ? rv.n : rv.depth;
            rv.exp_ov    = (rv.n > rv.depth);
            rv.core_wait = $urandom_range(1, 4);
            run_image(rv, $sformatf("rnd%0d", r));
            release_core(rv.core_wait, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
